// File: rtl/sub_32_nibble_serial.sv
// Multi-cycle subtractor: d = a + ~b + 1, one SLICE-bit lookahead slice per clock,
// least significant slice first, with valid/ready handshakes on both sides.
module sub_32_nibble_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MSB    = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, nb_reg, d_reg, d_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             borrow_reg, ovf_reg, zero_reg;

  logic [IDX_W-1:0] base;
  logic [SLICE-1:0] slice_a, slice_nb, prop, gen, sum;
  logic [SLICE:0]   c;
  logic             slice_cout;
  logic             last;

  assign last = (cnt == CNT_W'(NSLICE - 1));

  // The subtrahend is stored already inverted, so the slice is a plain lookahead adder
  always_comb begin
    base     = IDX_W'(int'(cnt) * SLICE);
    slice_a  = a_reg[base +: SLICE];
    slice_nb = nb_reg[base +: SLICE];
    prop     = slice_a ^ slice_nb;
    gen      = slice_a & slice_nb;
    c        = '0;
    c[0]     = carry;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = gen[i] | (prop[i] & c[i]);
    end
    sum        = prop ^ c[SLICE-1:0];
    slice_cout = c[SLICE];
    d_nxt      = d_reg;
    d_nxt[base +: SLICE] = sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg      <= '0;
      nb_reg     <= '0;
      d_reg      <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      borrow_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= a;
            nb_reg <= ~b;
            carry  <= 1'b1;
            cnt    <= '0;
          end
        end
        RUN: begin
          d_reg <= d_nxt;
          carry <= slice_cout;
          cnt   <= cnt + CNT_W'(1);
          // nb_reg holds ~b, so equal MSBs here mean the operand signs differ
          if (last) begin
            borrow_reg <= ~slice_cout;
            ovf_reg    <= (a_reg[MSB] == nb_reg[MSB]) & (d_nxt[MSB] != a_reg[MSB]);
            zero_reg   <= (d_nxt == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign d          = d_reg;
  assign borrow_out = borrow_reg;
  assign overflow   = ovf_reg;
  assign zero       = zero_reg;

endmodule

// File: tb/tb_sub_32_nibble_serial.sv
// Directed bench for sub_32_nibble_serial: expected results are queued at accept
// and compared when the DUT presents out_valid.
module tb_sub_32_nibble_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        borrow_out, overflow, zero;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] d;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  sub_32_nibble_serial dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d          (d),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Waits for in_ready, presents one operand pair for one accept edge, queues the reference
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
    int   n = 0;
    exp_t e;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_wait", {31'b0, in_ready}, 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    e.d      = av - bv;
    e.borrow = (av < bv);
    e.ovf    = (av[31] != bv[31]) && (e.d[31] != av[31]);
    e.zero   = (e.d == 32'd0);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collectResult(input string tag);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd8);
    checkOutput({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_d"}, d, e.d);
      checkOutput({tag, "_borrow"}, {31'b0, borrow_out}, {31'b0, e.borrow});
      checkOutput({tag, "_overflow"}, {31'b0, overflow}, {31'b0, e.ovf});
      checkOutput({tag, "_zero"}, {31'b0, zero}, {31'b0, e.zero});
    end
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_out_valid_clear"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] held_d;
    logic [2:0]  held_flags;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_d", d, 32'd0);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_flags", {29'b0, borrow_out, overflow, zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);

    applyStimulus(32'd5, 32'd3);
    collectResult("5m3");
    retire("5m3");

    applyStimulus(32'd3, 32'd5);
    collectResult("3m5");
    retire("3m5");

    applyStimulus(32'h8000_0000, 32'h0000_0001);
    collectResult("minneg");
    retire("minneg");

    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    collectResult("maxpos");
    retire("maxpos");

    applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    collectResult("equal");
    retire("equal");

    applyStimulus(32'h1234_5678, 32'h0);
    collectResult("bzero");
    retire("bzero");

    // Backpressure: result must hold while new operands are offered and refused
    applyStimulus(32'h0000_1000, 32'h0000_0FFF);
    collectResult("bp");
    held_d     = d;
    held_flags = {borrow_out, overflow, zero};
    a          = 32'hAAAA_AAAA;
    b          = 32'h5555_5555;
    in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_d_stable", d, held_d);
      checkOutput("bp_flags_stable", {29'b0, borrow_out, overflow, zero}, {29'b0, held_flags});
      checkOutput("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      checkOutput("bp_out_valid_high", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    retire("bp");
    @(posedge clk); #1;
    checkOutput("bp_no_stray_accept", {31'b0, in_ready}, 32'd1);
    applyStimulus(32'hFFFF_0000, 32'h0001_0001);
    collectResult("after_bp");
    retire("after_bp");

    // Reset during slice 3 of RUN must abort without any partial result
    applyStimulus(32'hCAFE_F00D, 32'h0BAD_BEEF);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_d", d, 32'd0);
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_flags", {29'b0, borrow_out, overflow, zero}, 32'd0);
    void'(sb.pop_back());
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("midrst_out_valid_after", {31'b0, out_valid}, 32'd0);
    applyStimulus(32'h10, 32'h01);
    collectResult("after_rst");
    checkOutput("after_rst_d_0f", d, 32'h0000_000F);
    retire("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
